// File: rtl/serial_arith_pkg.sv
// Shared constants and helpers for the bit-serial arithmetic units.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit-counter width; a one-bit counter is still needed at the narrowest width.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with a carry flop that can be preset (load) or advanced (en).
module serial_fa_cell (
    input  logic clk,
    input  logic rstn,
    input  logic a_i,
    input  logic b_i,
    input  logic load_i,
    input  logic load_val_i,
    input  logic en_i,
    output logic sum_c,
    output logic cout_c,
    output logic carry_q
);

    logic carry_d;

    assign sum_c  = a_i ^ b_i ^ carry_q;
    assign cout_c = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);

    // Load takes priority so a new operation can never inherit a stale carry.
    always_comb begin
        carry_d = carry_q;
        if (load_i) begin
            carry_d = load_val_i;
        end else if (en_i) begin
            carry_d = cout_c;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor with start/done handshake, accumulate mode and carry/overflow flags.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             sub,
    input  logic             acc,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    import serial_arith_pkg::*;

    localparam int unsigned      CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fa_load, fa_en, fa_sum, fa_cout, carry_q;

    serial_fa_cell u_fa (
        .clk        (clk),
        .rstn       (rstn),
        .a_i        (a_q[0]),
        .b_i        (b_q[0]),
        .load_i     (fa_load),
        .load_val_i (sub),
        .en_i       (fa_en),
        .sum_c      (fa_sum),
        .cout_c     (fa_cout),
        .carry_q    (carry_q)
    );

    // Next-state and datapath control; LSB is processed first, sum bits enter at the MSB.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        fa_load  = 1'b0;
        fa_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = acc ? result_q : a_in;
                    b_d     = sub ? ~b_in : b_in;
                    fa_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                fa_en = 1'b1;
                a_d   = {fa_sum, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // carry_q here is the carry into the MSB, fa_cout the carry out of it.
                    result_d = {fa_sum, a_q[WIDTH-1:1]};
                    cout_d   = fa_cout;
                    ovf_d    = carry_q ^ fa_cout;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: directed vectors at WIDTH 4 and 8, random ops against an arithmetic model, reset corners.
module tb_serial_addsub_ctrl;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    logic       start4 = 0, sub4 = 0, acc4 = 0;
    logic [3:0] a4 = '0, b4 = '0, res4;
    logic       busy4, done4, cout4, ovf4;

    logic       start8 = 0, sub8 = 0, acc8 = 0;
    logic [7:0] a8 = '0, b8 = '0, res8;
    logic       busy8, done8, cout8, ovf8;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural result each instance should currently hold (used by acc mode).
    logic [63:0] mres4 = '0;
    logic [63:0] mres8 = '0;

    serial_addsub_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rstn(rstn), .start(start4), .sub(sub4), .acc(acc4),
        .a_in(a4), .b_in(b4), .busy(busy4), .done(done4), .result(res4),
        .cout(cout4), .overflow(ovf4)
    );

    serial_addsub_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rstn(rstn), .start(start8), .sub(sub8), .acc(acc8),
        .a_in(a8), .b_in(b8), .busy(busy8), .done(done8), .result(res8),
        .cout(cout8), .overflow(ovf8)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          w;
        bit          s;
        bit          ac;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_r;
        bit          exp_co;
        bit          exp_ov;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction
    function automatic logic [63:0] get_res(input int w);
        return (w == 4) ? 64'(res4) : 64'(res8);
    endfunction
    function automatic logic get_cout(input int w);
        return (w == 4) ? cout4 : cout8;
    endfunction
    function automatic logic get_ovf(input int w);
        return (w == 4) ? ovf4 : ovf8;
    endfunction

    task automatic drive(input int w, input logic st, input logic s, input logic ac,
                         input logic [63:0] a, input logic [63:0] b);
        if (w == 4) begin
            start4 = st; sub4 = s; acc4 = ac; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            start8 = st; sub8 = s; acc8 = ac; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input int w, input bit s, input bit ac,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output bit co, output bit ov);
        logic [63:0] mask, opa, opb;
        longint sa, sb, sres, lim;
        mask = (64'd1 << w) - 64'd1;
        opa  = ac ? ((w == 4) ? mres4 : mres8) : (a & mask);
        opb  = b & mask;
        if (s) begin
            r  = (opa - opb) & mask;
            co = (opa >= opb);
        end else begin
            r  = (opa + opb) & mask;
            co = ((opa + opb) >> w) != 64'd0;
        end
        lim = longint'(64'd1 << (w - 1));
        sa  = longint'(opa);
        sb  = longint'(opb);
        if (sa >= lim) sa = sa - 2 * lim;
        if (sb >= lim) sb = sb - 2 * lim;
        sres = s ? (sa - sb) : (sa + sb);
        ov   = (sres >= lim) || (sres < -lim);
        if (w == 4) mres4 = r; else mres8 = r;
    endtask

    // One handshake: start pulse (or held start), checks busy length, done latency and pulse width.
    task automatic run_op(input int w, input bit s, input bit ac,
                          input logic [63:0] a, input logic [63:0] b, input bit hold_start,
                          output logic [63:0] r, output bit co, output bit ov);
        int  busy_n = 0;
        int  cyc    = 0;
        bit  seen   = 0;
        @(negedge clk);
        drive(w, 1'b1, s, ac, a, b);
        @(negedge clk);
        // Operands may change once start has been accepted.
        drive(w, hold_start, $urandom_range(0, 1), $urandom_range(0, 1), 64'($urandom), 64'($urandom));
        while (!seen && cyc < 3 * w + 10) begin
            if (get_done(w)) begin
                seen = 1;
            end else begin
                if (get_busy(w)) busy_n++;
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout w=%0d: got no done after %0d cycles required %0d", w, cyc, w);
            drive(w, 1'b0, 1'b0, 1'b0, '0, '0);
            r = '0; co = 0; ov = 0;
            return;
        end
        chk("busy_cycles", 64'(busy_n), 64'(w));
        chk("done_latency", 64'(cyc), 64'(w));
        chk("busy_in_done", 64'(get_busy(w)), 64'd0);
        r  = get_res(w);
        co = get_cout(w);
        ov = get_ovf(w);
        @(negedge clk);
        drive(w, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("done_pulse", 64'(get_done(w)), 64'd0);
        chk("result_hold", get_res(w), r);
        if (hold_start) begin
            repeat (3) begin
                @(negedge clk);
                chk("no_restart_busy", 64'(get_busy(w)), 64'd0);
                chk("no_restart_done", 64'(get_done(w)), 64'd0);
            end
        end
    endtask

    vec_t        vecs[$];
    logic [63:0] r, er;
    bit          co, ov, eco, eov;

    initial begin
        // Reset and idle behaviour.
        repeat (2) @(negedge clk);
        chk("rst_busy4", 64'(busy4), 64'd0);
        chk("rst_done4", 64'(done4), 64'd0);
        chk("rst_res4", 64'(res4), 64'd0);
        chk("rst_flags8", 64'({busy8, done8, cout8, ovf8}), 64'd0);
        chk("rst_res8", 64'(res8), 64'd0);
        rstn = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_hold4", 64'({busy4, done4, res4}), 64'd0);
        end

        // Directed vectors; the acc row depends on the row before it.
        vecs.push_back('{4, 0, 0, 64'h7,  64'h9,  64'h0,  1, 0});
        vecs.push_back('{4, 0, 0, 64'h5,  64'h4,  64'h9,  0, 1});
        vecs.push_back('{8, 1, 0, 64'h10, 64'h20, 64'hF0, 0, 0});
        vecs.push_back('{8, 1, 0, 64'h80, 64'h01, 64'h7F, 1, 1});
        vecs.push_back('{8, 0, 0, 64'h03, 64'h05, 64'h08, 0, 0});
        vecs.push_back('{8, 0, 1, 64'hEE, 64'h0A, 64'h12, 0, 0});
        vecs.push_back('{8, 1, 1, 64'h00, 64'h02, 64'h10, 1, 0});
        vecs.push_back('{4, 1, 0, 64'h0,  64'h1,  64'hF,  0, 0});
        foreach (vecs[i]) begin
            run_op(vecs[i].w, vecs[i].s, vecs[i].ac, vecs[i].a, vecs[i].b, (i == 5), r, co, ov);
            model(vecs[i].w, vecs[i].s, vecs[i].ac, vecs[i].a, vecs[i].b, er, eco, eov);
            chk($sformatf("vec%0d_result", i), r, vecs[i].exp_r);
            chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].exp_co));
            chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].exp_ov));
        end

        // Randomised operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            int          w;
            bit          s, ac;
            logic [63:0] a, b;
            w  = (i % 2 == 0) ? 4 : 8;
            s  = bit'($urandom_range(0, 1));
            ac = bit'($urandom_range(0, 3) == 0);
            a  = 64'($urandom);
            b  = 64'($urandom);
            run_op(w, s, ac, a, b, 1'b0, r, co, ov);
            model(w, s, ac, a, b, er, eco, eov);
            chk($sformatf("rnd%0d_result", i), r, er);
            chk($sformatf("rnd%0d_cout", i), 64'(co), 64'(eco));
            chk($sformatf("rnd%0d_ovf", i), 64'(ov), 64'(eov));
        end

        // Asynchronous reset two cycles into SHIFT.
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 1'b0, 64'h33, 64'h44);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("pre_rst_busy", 64'(busy8), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy8), 64'd0);
        chk("async_rst_done", 64'(done8), 64'd0);
        chk("async_rst_res8", 64'(res8), 64'd0);
        chk("async_rst_res4", 64'(res4), 64'd0);
        chk("async_rst_flags", 64'({cout8, ovf8}), 64'd0);
        mres4 = '0;
        mres8 = '0;
        @(negedge clk);
        rstn = 1'b1;
        // acc=1 after reset must accumulate onto a cleared result.
        run_op(8, 1'b0, 1'b1, 64'hFF, 64'h25, 1'b0, r, co, ov);
        model(8, 1'b0, 1'b1, 64'hFF, 64'h25, er, eco, eov);
        chk("post_rst_result", r, 64'h25);
        chk("post_rst_model", r, er);
        chk("post_rst_cout", 64'(co), 64'd0);
        run_op(8, 1'b0, 1'b0, 64'h40, 64'h41, 1'b0, r, co, ov);
        chk("post_rst_sum", r, 64'h81);
        chk("post_rst_ovf", 64'(ov), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
